// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Opcodes, FSM states, instruction classes and ALUOp codes for the
//            multicycle MIPS controller.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_ANDI  = 6'h0C;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    localparam logic [2:0] C_ALU_ADD  = 3'b100;
    localparam logic [2:0] C_ALU_SUB  = 3'b001;
    localparam logic [2:0] C_ALU_ORI  = 3'b101;
    localparam logic [2:0] C_ALU_ANDI = 3'b110;
    localparam logic [2:0] C_ALU_LUI  = 3'b011;
    localparam logic [2:0] C_ALU_R    = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE   = 4'd0,
        CL_IALU    = 4'd1,
        CL_LW      = 4'd2,
        CL_SW      = 4'd3,
        CL_BEQ     = 4'd4,
        CL_BNE     = 4'd5,
        CL_J       = 4'd6,
        CL_JAL     = 4'd7,
        CL_ILLEGAL = 4'd8
    } opclass_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       jal;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_out_t;

    // ALU code for the immediate-ALU group; ADDI shares the ADD code
    function automatic logic [2:0] ialu_code(input logic [5:0] op);
        case (op)
            C_OP_ORI:  return C_ALU_ORI;
            C_OP_ANDI: return C_ALU_ANDI;
            C_OP_LUI:  return C_ALU_LUI;
            default:   return C_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Controller <-> datapath bundle: instruction/status inputs and all
//            datapath enables/selects.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         OP;
    logic               Zero;
    logic               mem_ready;
    logic               PCWrite;
    logic               IRWrite;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               Jal;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic               instr_done;
    logic               illegal_op;

    modport master (
        input  OP, Zero, mem_ready,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, Jal, ALUSrcB, PCSource, ALUOp,
               instr_done, illegal_op
    );

    modport slave (
        output OP, Zero, mem_ready,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, Jal, ALUSrcB, PCSource, ALUOp,
               instr_done, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_opclass.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_opclass
// Brief    : Combinational opcode -> instruction class decoder.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_opclass
    import mips_ctrl_pkg::*;
(
    input  wire logic [5:0] i_op,
    output opclass_t        o_class
);

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_op)
            C_OP_RTYPE: o_class = CL_RTYPE;
            C_OP_ADDI,
            C_OP_ORI,
            C_OP_ANDI,
            C_OP_LUI:   o_class = CL_IALU;
            C_OP_LW:    o_class = CL_LW;
            C_OP_SW:    o_class = CL_SW;
            C_OP_BEQ:   o_class = CL_BEQ;
            C_OP_BNE:   o_class = CL_BNE;
            C_OP_J:     o_class = CL_J;
            C_OP_JAL:   o_class = CL_JAL;
            default:    o_class = CL_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Five-state multicycle MIPS controller with memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int MEM_HS  = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    multicycle_control_if.master bus
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       w_ready;
    logic [5:0] w_cls_op;
    opclass_t   w_class;
    ctrl_out_t  w_out;
    ctrl_out_t  w_gated;

    assign w_ready  = (MEM_HS != 0) ? bus.mem_ready : 1'b1;
    // DECODE classifies the live opcode; later states use the latched copy
    assign w_cls_op = (state_q == ST_DECODE) ? bus.OP : op_q;

    ctrl_opclass u_opclass (
        .i_op    (w_cls_op),
        .o_class (w_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        w_out   = '0;
        case (state_q)
            ST_FETCH: begin
                w_out.mem_read  = 1'b1;
                w_out.alu_src_b = 2'b01;
                w_out.alu_op    = C_ALU_ADD;
                w_out.ir_write  = w_ready;
                w_out.pc_write  = w_ready;
                if (w_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d            = bus.OP;
                w_out.alu_src_b = 2'b11;
                w_out.alu_op    = C_ALU_ADD;
                case (w_class)
                    CL_J, CL_JAL: begin
                        w_out.pc_write   = 1'b1;
                        w_out.pc_source  = 2'b10;
                        w_out.instr_done = 1'b1;
                        w_out.reg_write  = (w_class == CL_JAL);
                        w_out.jal        = (w_class == CL_JAL);
                        state_d          = ST_FETCH;
                    end
                    CL_ILLEGAL: begin
                        w_out.illegal_op = 1'b1;
                        w_out.instr_done = 1'b1;
                        state_d          = ST_FETCH;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                w_out.alu_src_a = 1'b1;
                case (w_class)
                    CL_RTYPE: begin
                        w_out.alu_op = C_ALU_R;
                        state_d      = ST_WB;
                    end
                    CL_IALU: begin
                        w_out.alu_src_b = 2'b10;
                        w_out.alu_op    = ialu_code(op_q);
                        state_d         = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        w_out.alu_src_b = 2'b10;
                        w_out.alu_op    = C_ALU_ADD;
                        state_d         = ST_MEM;
                    end
                    CL_BEQ, CL_BNE: begin
                        w_out.alu_op     = C_ALU_SUB;
                        w_out.pc_source  = 2'b01;
                        w_out.pc_write   = (w_class == CL_BEQ) ? bus.Zero : ~bus.Zero;
                        w_out.instr_done = 1'b1;
                        state_d          = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                w_out.iord      = 1'b1;
                w_out.mem_read  = (w_class == CL_LW);
                w_out.mem_write = (w_class == CL_SW);
                if (w_ready) begin
                    if (w_class == CL_LW) begin
                        state_d = ST_WB;
                    end else begin
                        w_out.instr_done = (w_class == CL_SW);
                        state_d          = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                w_out.reg_write  = 1'b1;
                w_out.reg_dst    = (w_class == CL_RTYPE);
                w_out.memto_reg  = (w_class == CL_LW);
                w_out.instr_done = 1'b1;
                state_d          = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset forces every output low, even while the register still holds a stale state
    assign w_gated = reset ? '0 : w_out;

    assign bus.PCWrite    = w_gated.pc_write;
    assign bus.IRWrite    = w_gated.ir_write;
    assign bus.IorD       = w_gated.iord;
    assign bus.MemRead    = w_gated.mem_read;
    assign bus.MemWrite   = w_gated.mem_write;
    assign bus.MemtoReg   = w_gated.memto_reg;
    assign bus.RegDst     = w_gated.reg_dst;
    assign bus.RegWrite   = w_gated.reg_write;
    assign bus.ALUSrcA    = w_gated.alu_src_a;
    assign bus.Jal        = w_gated.jal;
    assign bus.ALUSrcB    = w_gated.alu_src_b;
    assign bus.PCSource   = w_gated.pc_source;
    assign bus.ALUOp      = ALUOP_W'(w_gated.alu_op);
    assign bus.instr_done = w_gated.instr_done;
    assign bus.illegal_op = w_gated.illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Randomized self-checking bench; per-instruction expected cycle
//            lists are built from the instruction's class and wait plan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw, irw, iord, mr, mw, m2r, rdst, rw, asa, jal;
        logic [1:0] asb, pcs;
        logic [2:0] aluop;
        logic       done, ill;
    } ov_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       rdy;
        logic [2:0] st;
        ov_t        exp;
    } step_t;

    localparam int K_R = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_BNE = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(3)) if1 ();
    multicycle_control_if #(.ALUOP_W(3)) if2 ();

    multicycle_control #(.ALUOP_W(3), .MEM_HS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    multicycle_control #(.ALUOP_W(3), .MEM_HS(0)) dut_nohs (
        .clk   (clk),
        .reset (reset2),
        .bus   (if2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ov_t obs1();
        ov_t o;
        o = {if1.PCWrite, if1.IRWrite, if1.IorD, if1.MemRead, if1.MemWrite,
             if1.MemtoReg, if1.RegDst, if1.RegWrite, if1.ALUSrcA, if1.Jal,
             if1.ALUSrcB, if1.PCSource, if1.ALUOp, if1.instr_done, if1.illegal_op};
        return o;
    endfunction

    function automatic ov_t obs2();
        ov_t o;
        o = {if2.PCWrite, if2.IRWrite, if2.IorD, if2.MemRead, if2.MemWrite,
             if2.MemtoReg, if2.RegDst, if2.RegWrite, if2.ALUSrcA, if2.Jal,
             if2.ALUSrcB, if2.PCSource, if2.ALUOp, if2.instr_done, if2.illegal_op};
        return o;
    endfunction

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'h00:                      return K_R;
            6'h08, 6'h0C, 6'h0D, 6'h0F: return K_IALU;
            6'h23:                      return K_LW;
            6'h2B:                      return K_SW;
            6'h04:                      return K_BEQ;
            6'h05:                      return K_BNE;
            6'h02:                      return K_J;
            6'h03:                      return K_JAL;
            default:                    return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'h0D:   return 3'b101;
            6'h0C:   return 3'b110;
            6'h0F:   return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    function automatic string st_name(input logic [2:0] s);
        case (s)
            3'd0:    return "fetch";
            3'd1:    return "decode";
            3'd2:    return "exec";
            3'd3:    return "mem";
            default: return "wb";
        endcase
    endfunction

    // Plans one instruction as a list of cycles, then replays it against the DUT.
    // abort_at >= 0 asserts reset on that cycle index instead of finishing.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fwait,
                             input int mwait, input int abort_at);
        step_t q[$];
        step_t s;
        ov_t   e;
        ov_t   got;
        int    k;
        int    lat;
        int    done_at;
        k = cls(op);
        for (int i = 0; i <= fwait; i++) begin
            e = '0; e.mr = 1'b1; e.asb = 2'b01; e.aluop = 3'b100;
            e.irw = (i == fwait); e.pcw = (i == fwait);
            s.op = op; s.z = z; s.rdy = (i == fwait); s.st = 3'd0; s.exp = e;
            q.push_back(s);
        end
        e = '0; e.asb = 2'b11; e.aluop = 3'b100;
        if (k == K_J || k == K_JAL) begin e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1; end
        if (k == K_JAL) begin e.rw = 1'b1; e.jal = 1'b1; end
        if (k == K_ILL) begin e.ill = 1'b1; e.done = 1'b1; end
        s.op = op; s.z = z; s.rdy = 1'($urandom); s.st = 3'd1; s.exp = e;
        q.push_back(s);
        if (!(k inside {K_J, K_JAL, K_ILL})) begin
            e = '0; e.asa = 1'b1;
            case (k)
                K_R:          e.aluop = 3'b111;
                K_IALU:       begin e.asb = 2'b10; e.aluop = alu_of(op); end
                K_LW, K_SW:   begin e.asb = 2'b10; e.aluop = 3'b100; end
                default: begin
                    e.aluop = 3'b001; e.pcs = 2'b01; e.done = 1'b1;
                    e.pcw = (k == K_BEQ) ? z : ~z;
                end
            endcase
            s.op = 6'($urandom); s.z = z; s.rdy = 1'($urandom); s.st = 3'd2; s.exp = e;
            q.push_back(s);
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i <= mwait; i++) begin
                    e = '0; e.iord = 1'b1; e.mr = (k == K_LW); e.mw = (k == K_SW);
                    e.done = (k == K_SW) && (i == mwait);
                    s.op = 6'($urandom); s.z = z; s.rdy = (i == mwait); s.st = 3'd3; s.exp = e;
                    q.push_back(s);
                end
            end
            if (k == K_R || k == K_IALU || k == K_LW) begin
                e = '0; e.rw = 1'b1; e.rdst = (k == K_R); e.m2r = (k == K_LW); e.done = 1'b1;
                s.op = 6'($urandom); s.z = z; s.rdy = 1'($urandom); s.st = 3'd4; s.exp = e;
                q.push_back(s);
            end
        end

        done_at = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                if1.OP = 6'($urandom); if1.Zero = 1'($urandom); if1.mem_ready = 1'b1;
                #4;
                check_val("rst_abort", 32'(obs1()), 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if1.OP = q[i].op; if1.Zero = q[i].z; if1.mem_ready = q[i].rdy;
            #4;
            got = obs1();
            check_val(st_name(q[i].st), 32'(got), 32'(q[i].exp));
            if (got.done && done_at == 0) done_at = i + 1;
            @(posedge clk); #1;
        end

        case (k)
            K_J, K_JAL, K_ILL: lat = 2;
            K_BEQ, K_BNE:      lat = 3;
            K_LW:              lat = 5;
            default:           lat = 4;
        endcase
        lat += fwait;
        if (k == K_LW || k == K_SW) lat += mwait;
        check_val("latency", 32'(done_at), 32'(lat));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pool [11];
        ov_t        e2 [4];
        logic [5:0] op;
        int         ab;
        pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

        reset = 1'b1; reset2 = 1'b1;
        if1.OP = 6'h23; if1.Zero = 1'b0; if1.mem_ready = 1'b1;
        if2.OP = 6'h2B; if2.Zero = 1'b0; if2.mem_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            #4;
            check_val("rst_hold", 32'(obs1()), 32'd0);
            check_val("rst_hold2", 32'(obs2()), 32'd0);
            @(posedge clk); #1;
        end

        // Handshake-disabled build: SW completes in 4 cycles with mem_ready stuck low
        e2[0] = '0; e2[0].mr = 1'b1; e2[0].asb = 2'b01; e2[0].aluop = 3'b100;
        e2[0].irw = 1'b1; e2[0].pcw = 1'b1;
        e2[1] = '0; e2[1].asb = 2'b11; e2[1].aluop = 3'b100;
        e2[2] = '0; e2[2].asa = 1'b1; e2[2].asb = 2'b10; e2[2].aluop = 3'b100;
        e2[3] = '0; e2[3].iord = 1'b1; e2[3].mw = 1'b1; e2[3].done = 1'b1;
        reset2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if1.OP = 6'($urandom);
            #4;
            check_val("nohs_sw", 32'(obs2()), 32'(e2[i]));
            check_val("rst_hold", 32'(obs1()), 32'd0);
            @(posedge clk); #1;
            if (i == 1) if2.OP = 6'($urandom);
        end
        reset2 = 1'b1;
        reset  = 1'b0;

        run_instr(6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h23, 1'b0, 0, 2, -1);
        run_instr(6'h04, 1'b1, 0, 0, -1);
        run_instr(6'h05, 1'b1, 0, 0, -1);
        run_instr(6'h04, 1'b0, 1, 0, -1);
        run_instr(6'h03, 1'b0, 0, 0, -1);
        run_instr(6'h02, 1'b1, 0, 0, -1);
        run_instr(6'h3F, 1'b0, 0, 0, -1);
        run_instr(6'h2B, 1'b0, 0, 3, 4);
        run_instr(6'h2B, 1'b0, 2, 1, -1);
        run_instr(6'h0D, 1'b0, 0, 0, -1);
        run_instr(6'h0F, 1'b0, 0, 0, -1);
        run_instr(6'h23, 1'b0, 1, 0, 1);

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pool[$urandom_range(0, 10)];
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(op, 1'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 3: width of the ALUOp output; values wider than 3 SHALL zero-extend the encodings in REQ-020.
REQ-002 Parameter MEM_HS, default 1: 1 = honour the mem_ready handshake; 0 = mem_ready ignored and treated as constant 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 OP  input  6  opcode field of the instruction register.
REQ-006 Zero  input  1  ALU zero flag, sampled in EXEC.
REQ-007 mem_ready  input  1  memory has completed the current read/write this cycle.
REQ-008 PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Jal  output  1 each  datapath enables/selects.
REQ-009 ALUSrcB  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-010 PCSource  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump target.
REQ-011 ALUOp  output  ALUOP_W  ALU operation code.
REQ-012 instr_done  output  1  one-cycle pulse on the final cycle of every instruction.
REQ-013 illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB; opcode SHALL be latched into op_q on the DECODE cycle and used for all later decisions of that instruction.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD; J -> PCWrite=1, PCSource=10, instr_done=1, next FETCH; JAL -> same plus RegWrite=1, Jal=1; illegal -> illegal_op=1, instr_done=1, next FETCH; all others -> EXEC.
REQ-017 EXEC: ALUSrcA=1; R-type: ALUSrcB=00, ALUOp=R -> WB; ADDI/ORI/ANDI/LUI: ALUSrcB=10 -> WB; LW/SW: ALUSrcB=10, ALUOp=ADD -> MEM; BEQ: ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWrite=Zero, instr_done=1 -> FETCH; BNE: identical but PCWrite=~Zero.
REQ-018 MEM: IorD=1; LW: MemRead=1, SW: MemWrite=1; hold both while mem_ready=0; on mem_ready=1 LW -> WB, SW -> FETCH with instr_done=1.
REQ-019 WB: RegWrite=1, RegDst=1 only for R-type, MemtoReg=1 only for LW, instr_done=1, next FETCH.
REQ-020 ALUOp codes: ADD=100, SUB=001, ORI=101, ANDI=110, LUI=011, R=111; ADDI uses ADD.
REQ-021 Every output not named for a state SHALL be 0 in that state; outputs are functions of state, op_q (OP in DECODE), Zero and mem_ready only.
REQ-022 Zero-wait latencies (cycles, FETCH to instr_done): J/JAL 2, BEQ/BNE 3, R/I-ALU 4, SW 4, LW 5; each mem_ready=0 cycle adds exactly one cycle.
REQ-023 MemRead and MemWrite SHALL never be asserted in the same cycle; RegWrite and PCWrite SHALL be asserted together only for JAL.

Reset
REQ-024 While reset=1 every output SHALL be 0 (including MemRead), regardless of state.
REQ-025 On the first edge with reset=1 the state SHALL become FETCH and op_q SHALL become 0; a reset during a MEM or FETCH wait SHALL abandon the access with no further write enable.

Structure
REQ-026 Package mips_ctrl_pkg SHALL hold opcode constants, the state enum, and ALUOp codes.
REQ-027 One combinational sub-module ctrl_opclass SHALL map a 6-bit opcode to an instruction class (RTYPE, IALU, LW, SW, BEQ, BNE, J, JAL, ILLEGAL).

Verification
REQ-028 R-type (OP=0x00), mem_ready=1 -> DECODE, EXEC ALUOp=111, WB RegWrite=1, RegDst=1, instr_done at cycle 4.
REQ-029 LW (OP=0x23) with mem_ready low 2 cycles in MEM -> MemRead held 3 cycles, WB MemtoReg=1, instr_done at cycle 7.
REQ-030 BEQ (0x04) Zero=1 -> PCWrite=1, PCSource=01 in EXEC; BNE (0x05) Zero=1 -> PCWrite=0; both instr_done at cycle 3.
REQ-031 JAL (0x03) -> DECODE asserts PCWrite=1, RegWrite=1, Jal=1, PCSource=10; next cycle FETCH.
REQ-032 OP=0x3F -> illegal_op pulse in DECODE, no write enable, return to FETCH.
REQ-033 SW (0x2B) with reset asserted during MEM wait -> MemWrite=0 on the reset cycle, FETCH afterwards; MEM_HS=0 build completes SW in 4 cycles with mem_ready=0.
